// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Op codes mirror the external ALU's encoding.
package alu_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/alu_arb_rr_pick.sv
// Two-input grant picker: round-robin by default,
// fixed priority (req 0 wins) with ALU_ARB_FIXED_PRIO_EN.
module alu_arb_rr_pick
  import alu_arb_pkg::*;
(
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic               rr,
`endif
  output logic [NUM_REQ-1:0] grant
);

  // one-hot grant; a lone request wins outright
  always_comb begin
    grant = '0;
    if (en) begin
      if (req == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = rr ? 2'b10 : 2'b01;
`endif
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU
// and registers the result. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  input  logic [1:0]         req_op0,
  input  logic [1:0]         req_op1,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  input  logic               rsp_ready
);

  state_t             state_q;
  state_t             state_d;
  logic [NUM_REQ-1:0] grant;
  logic               can_accept;
  logic               hs;
  logic               gid;

  assign can_accept = (state_q == IDLE) | rsp_ready;
  assign hs         = |grant;
  assign gid        = grant[1];
  assign req_ready  = grant;
  assign rsp_valid  = (state_q == RESP);

`ifdef ALU_ARB_FIXED_PRIO_EN
  alu_arb_rr_pick u_pick (
    .en    (can_accept & rst_n),
    .req   (req_valid),
    .grant (grant)
  );
`else
  logic rr_q;

  alu_arb_rr_pick u_pick (
    .en    (can_accept & rst_n),
    .req   (req_valid),
    .rr    (rr_q),
    .grant (grant)
  );

  // priority flips away from whoever just got served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (hs) begin
      rr_q <= ~gid;
    end
  end
`endif

  // steer the granted requester onto the shared ALU
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    unique case (1'b1)
      grant[0]: begin
        alu_a  = req_a0;
        alu_b  = req_b0;
        alu_op = req_op0;
      end
      grant[1]: begin
        alu_a  = req_a1;
        alu_b  = req_b1;
        alu_op = req_op1;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: a new accept always lands in RESP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (hs) state_d = RESP;
      RESP: begin
        if (hs) begin
          state_d = RESP;
        end else if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // capture the ALU result on accept, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= 1'b0;
      rsp_data <= '0;
    end else if (hs) begin
      rsp_id   <= gid;
      rsp_data <= alu_result;
    end
  end

endmodule
